// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative encryption datapath.
//   - block, round-count and expanded-key widths
//   - FSM state type used by aes_encrypt_iter (IDLE / ROUND / DONE)
//   - S-box lookup and GF(2^8) multiply-by-2 / multiply-by-3 helpers
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_NR     = 10;
  localparam int AES_XKEY_W = AES_BLK_W * (AES_NR + 1);  // 1408

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, which is simply {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// -----------------------------------------------------------------------------
// aes_encrypt_iter_if
// Input and output valid/ready channels of the iterative AES-128 encryptor.
//   in_valid / in_ready   : plaintext + expanded_key offered / block idle
//   plaintext    [127:0]  : byte 0 at [127:120]
//   expanded_key [1407:0] : round key r at [128*r +: 128]
//   out_valid / out_ready : ciphertext offered / consumer takes it
//   ciphertext   [127:0]  : same byte order as plaintext
// master = sender/consumer side, slave = encryptor side.
// -----------------------------------------------------------------------------
interface aes_encrypt_iter_if;

  logic                            in_valid;
  logic                            in_ready;
  logic [aes_pkg::AES_BLK_W-1:0]   plaintext;
  logic [aes_pkg::AES_XKEY_W-1:0]  expanded_key;
  logic                            out_valid;
  logic                            out_ready;
  logic [aes_pkg::AES_BLK_W-1:0]   ciphertext;

  modport master (
    output in_valid, plaintext, expanded_key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, expanded_key, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/aes_round.sv
// -----------------------------------------------------------------------------
// aes_round
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey
// Ports:
//   state_in    [127:0] : round input, byte 0 at [127:120], column-major
//   round_key   [127:0] : key for this round
//   final_round         : 1 drops MixColumns
//   state_out   [127:0] : round result
// -----------------------------------------------------------------------------
module aes_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  input  logic                 final_round,
  output logic [AES_BLK_W-1:0] state_out
);

  // Byte i is row (i % 4), column (i / 4).
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    // NOTE: every array and the output get a full default before the loops, so
    // no path leaves a bit unassigned and no latch is inferred.
    sb        = '{default: '0};
    sr        = '{default: '0};
    mc        = '{default: '0};
    state_out = '0;

    for (int i = 0; i < 16; i++)
      sb[i] = sbox(state_in[AES_BLK_W-1-8*i -: 8]);

    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];

    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gf_mul2(sr[4*c]) ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gf_mul2(sr[4*c+1]) ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
      mc[4*c+3] = gf_mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
    end

    for (int i = 0; i < 16; i++)
      state_out[AES_BLK_W-1-8*i -: 8] = (final_round ? sr[i] : mc[i])
                                        ^ round_key[AES_BLK_W-1-8*i -: 8];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_encrypt_iter
// Iterative AES-128 encryption: initial AddRoundKey on accept, then one round
// per clock for ten clocks, result held on a valid/ready output until taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_encrypt_iter_if.slave (in_valid/in_ready, plaintext,
//                expanded_key, out_valid/out_ready, ciphertext)
// Parameter:
//   NR : cipher rounds, only 10 (AES-128) is supported
// Build option:
//   AES_ENC_ZEROIZE_EN - when defined, the data state and the key register are
//   cleared on the output handshake so ciphertext reads 0 while idle; when
//   undefined, the last result stays visible until the next accept.
// -----------------------------------------------------------------------------
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_encrypt_iter_if.slave    bus
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_fsm_e              fsm_q, fsm_d;
  logic [3:0]            rcnt_q;
  logic [AES_BLK_W-1:0]  state_q;
  logic [AES_XKEY_W-1:0] key_q;
  logic [AES_BLK_W-1:0]  round_key;
  logic [AES_BLK_W-1:0]  round_out;
  logic                  accept;
  logic                  out_fire;
  logic                  rcnt_ok;
  logic                  final_round;

  // Handshake outputs come from the registered FSM state only.
  assign bus.in_ready   = (fsm_q == IDLE);
  assign bus.out_valid  = (fsm_q == DONE);
  assign bus.ciphertext = state_q;

  assign accept      = bus.in_valid  && (fsm_q == IDLE);
  assign out_fire    = bus.out_ready && (fsm_q == DONE);
  assign rcnt_ok     = (rcnt_q != 4'd0) && (rcnt_q <= LAST_RND);
  assign final_round = (rcnt_q == LAST_RND);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = ROUND;
      // A corrupted round counter abandons the block rather than emitting it.
      ROUND:   if (!rcnt_ok)        fsm_d = IDLE;
               else if (final_round) fsm_d = DONE;
      DONE:    if (out_fire) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round-key select and round logic
  // ---------------------------------------------------------------------------
  always_comb begin
    round_key = '0;
    if (rcnt_ok) round_key = key_q[int'(rcnt_q)*AES_BLK_W +: AES_BLK_W];
  end

  aes_round u_round (
    .state_in    (state_q),
    .round_key   (round_key),
    .final_round (final_round),
    .state_out   (round_out)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      state_q <= '0;
      // NOTE: the wide key register is reset on purpose: a reset must not leave
      // the previous key schedule readable inside the block.
      key_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            // Round key 0 comes straight from the input; the register copy of
            // it is never read again.
            state_q <= bus.plaintext ^ bus.expanded_key[AES_BLK_W-1:0];
            key_q   <= bus.expanded_key;
            rcnt_q  <= 4'd1;
          end
        end
        ROUND: begin
          if (rcnt_ok) begin
            state_q <= round_out;
            rcnt_q  <= final_round ? 4'd0 : rcnt_q + 4'd1;
          end else begin
            rcnt_q  <= '0;
          end
        end
        DONE: begin
`ifdef AES_ENC_ZEROIZE_EN
          if (out_fire) begin
            state_q <= '0;
            key_q   <= '0;
          end
`endif
        end
        default: rcnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_encrypt_iter
// Self-checking bench for aes_encrypt_iter. The reference model derives the
// S-box from GF(2^8) inversion plus the affine map, expands keys itself and
// runs the cipher on a 4x4 byte matrix. Honours AES_ENC_ZEROIZE_EN for the
// idle-output expectation.
// -----------------------------------------------------------------------------
module tb_aes_encrypt_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;

  aes_encrypt_iter_if bus ();

  aes_encrypt_iter #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] last_ct;
  logic [7:0]   sbox_m [256];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic init_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int u = 1; u < 256; u++)
        if (gf_mul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] xk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    xk = '0;
    for (int r = 0; r < 11; r++)
      xk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return xk;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt,
                                               input logic [1407:0] xk);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] rk, res;
    base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ xk[127-8*(r+4*c) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = xk[128*rnd +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_m[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd == 10) begin
            s[r][c] = t[r][c];
          end else begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(base[(k-r+4)%4], t[k][c]);
            s[r][c] = acc;
          end
        end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [1407:0] rand_xkey();
    logic [1407:0] v;
    for (int i = 0; i < 44; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, DUT idle)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [127:0] pt, input logic [1407:0] xk);
    bus.in_valid     = 1'b1;
    bus.plaintext    = pt;
    bus.expanded_key = xk;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.plaintext    = rand_blk();
    bus.expanded_key = rand_xkey();
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.ciphertext !== 128'h0) begin n_fail++; $display("FAIL reset_ciphertext: got %h want 0", bus.ciphertext); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_fips_b();
    int n;
    send(PT_B, expand_key(KEY_B));
    wait_out(n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL fips_b_latency: got %0d edges want 10", n); end
    n_tests++; if (bus.ciphertext !== CT_B) begin n_fail++; $display("FAIL fips_b_ct: got %h want %h", bus.ciphertext, CT_B); end
    take();
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fips_b_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    last_ct = CT_B;
  endtask

  task automatic test_idle_output();
    logic [127:0] exp_idle;
    int bad;
`ifdef AES_ENC_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = last_ct;
`endif
    bad = 0;
    repeat (3) begin
      if (bus.ciphertext !== exp_idle || bus.in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_ct: got %h want %h (%0d bad cycles)", bus.ciphertext, exp_idle, bad); end
  endtask

  task automatic test_back_to_back();
    logic [127:0]  pts [4];
    logic [1407:0] xks [4];
    logic [127:0]  exp_q [$];
    logic [127:0]  e;
    int            acc_cyc [$];
    int            idx, got, cyc;
    pts[0] = PT_C;
    xks[0] = expand_key(KEY_C);
    for (int k = 1; k < 4; k++) begin
      pts[k] = rand_blk();
      xks[k] = expand_key(rand_blk());
    end
    idx = 0; got = 0; cyc = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (bus.out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_tests++; if (bus.ciphertext !== e) begin n_fail++; $display("FAIL b2b_ct[%0d]: got %h want %h", got, bus.ciphertext, e); end
        if (got == 0) begin
          n_tests++; if (bus.ciphertext !== CT_C) begin n_fail++; $display("FAIL fips_c_ct: got %h want %h", bus.ciphertext, CT_C); end
        end
        got++;
      end
      if (bus.in_ready === 1'b1 && idx < 4) begin
        bus.in_valid     = 1'b1;
        bus.plaintext    = pts[idx];
        bus.expanded_key = xks[idx];
        exp_q.push_back(ref_encrypt(pts[idx], xks[idx]));
        acc_cyc.push_back(cyc);
        idx++;
      end else if (idx == 4) begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4", got); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_tests++; if (acc_cyc[i] - acc_cyc[i-1] != 12) begin
        n_fail++; $display("FAIL b2b_interval[%0d]: got %0d clocks want 12", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0]  pt, e;
    logic [1407:0] xk;
    int n, bad;
    pt = rand_blk();
    xk = expand_key(rand_blk());
    e  = ref_encrypt(pt, xk);
    send(pt, xk);
    wait_out(n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL bp_latency: got %0d edges want 10", n); end
    bus.in_valid     = 1'b1;
    bus.plaintext    = rand_blk();
    bus.expanded_key = rand_xkey();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ciphertext !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall: %0d bad cycles, ct=%h want %h", bad, bus.ciphertext, e); end
    n_tests++; if (bus.ciphertext !== e) begin n_fail++; $display("FAIL bp_ct: got %h want %h", bus.ciphertext, e); end
    take();
    n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_single_handshake: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    send(PT_B, expand_key(KEY_B));
    @(negedge clk);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.plaintext    = rand_blk();
    bus.expanded_key = rand_xkey();
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(n);
    n_tests++; if (n != 7) begin n_fail++; $display("FAIL busy_latency: got %0d edges want 7", n); end
    n_tests++; if (bus.ciphertext !== CT_B) begin n_fail++; $display("FAIL busy_ct: got %h want %h", bus.ciphertext, CT_B); end
    take();
  endtask

  task automatic test_reset_mid_round();
    logic [127:0]  pt, e;
    logic [1407:0] xk;
    int n, bad;
    send(rand_blk(), expand_key(rand_blk()));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    n_tests++; if (bus.ciphertext !== 128'h0) begin n_fail++; $display("FAIL midrst_ct: got %h want 0", bus.ciphertext); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midrst_discard: %0d cycles not idle", bad); end
    pt = rand_blk();
    xk = expand_key(rand_blk());
    e  = ref_encrypt(pt, xk);
    send(pt, xk);
    wait_out(n);
    n_tests++; if (n != 10) begin n_fail++; $display("FAIL midrst_next_latency: got %0d edges want 10", n); end
    n_tests++; if (bus.ciphertext !== e) begin n_fail++; $display("FAIL midrst_next_ct: got %h want %h", bus.ciphertext, e); end
    take();
  endtask

  task automatic test_random();
    logic [127:0]  pt, e;
    logic [1407:0] xk;
    int n;
    for (int it = 0; it < 6; it++) begin
      pt = rand_blk();
      xk = expand_key(rand_blk());
      e  = ref_encrypt(pt, xk);
      send(pt, xk);
      wait_out(n);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      n_tests++; if (n != 10 || bus.ciphertext !== e) begin
        n_fail++; $display("FAIL rand_ct[%0d]: got %h after %0d edges want %h after 10", it, bus.ciphertext, n, e);
      end
      take();
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.plaintext    = '0;
    bus.expanded_key = '0;
    last_ct          = '0;
    init_sbox();
    test_reset();
    test_fips_b();
    test_idle_output();
    test_back_to_back();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_round();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
